// File: rtl/redmule_z_store_gen_pkg.sv
// Shared types and constants for the RedMulE Z store address/strobe generator.
// Also holds the helper that resolves the row count of the current block.
package redmule_z_store_gen_pkg;

  localparam int unsigned Z_DATA_W      = 288;
  localparam int unsigned Z_DATAW       = 256;
  localparam int unsigned Z_BITW        = 16;
  localparam int unsigned Z_ADDR_W      = 32;
  localparam int unsigned Z_ARRAY_WIDTH = 12;
  localparam int unsigned Z_STRB        = Z_DATA_W / 8;
  localparam int unsigned Z_RLFT_W      = $clog2(Z_ARRAY_WIDTH) + 1;
  localparam int unsigned Z_CLFT_W      = $clog2(Z_DATAW / Z_BITW) + 1;

  typedef enum logic [1:0] {
    Z_IDLE = 2'd0,
    Z_RUN  = 2'd1,
    Z_DONE = 2'd2
  } z_store_state_e;

  typedef struct packed {
    logic                start;
    logic                clear;
    logic [Z_ADDR_W-1:0] addr;
    logic [31:0]         d0_stride;
    logic [31:0]         d2_stride;
    logic [15:0]         n_blocks;
    logic [15:0]         col_blocks;
    logic [Z_RLFT_W-1:0] rows_lftovr;
    logic [Z_CLFT_W-1:0] cols_lftovr;
  } z_store_ctrl_t;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              st_valid;
    logic [Z_STRB-1:0] st_strb;
  } z_store_flgs_t;

  // A zero leftover means the final block is a full ARRAY_WIDTH rows tall.
  function automatic logic [Z_RLFT_W-1:0] rows_in_block(input logic                last_blk,
                                                         input logic [Z_RLFT_W-1:0] rows_lftovr);
    if (last_blk && (rows_lftovr != '0)) return rows_lftovr;
    return Z_RLFT_W'(Z_ARRAY_WIDTH);
  endfunction

endpackage

// File: rtl/redmule_z_strb_gen.sv
// Leftover-to-byte-strobe decoder: full payload strobes, or only the bytes of
// the first lftovr elements when partial is set. MemDw bytes always stay 0.
module redmule_z_strb_gen #(
  parameter int unsigned DATA_W = 288,
  parameter int unsigned DATAW  = 256,
  parameter int unsigned BITW   = 16,
  parameter int unsigned LFT_W  = $clog2(DATAW / BITW) + 1,
  parameter int unsigned STRB   = DATA_W / 8
) (
  input  logic             partial,
  input  logic [LFT_W-1:0] lftovr,
  output logic [STRB-1:0]  strb
);

  logic [31:0] n_bytes;

  always_comb begin
    n_bytes = 32'(lftovr) * (BITW / 8);
    strb    = '0;
    for (int unsigned i = 0; i < DATAW / 8; i++) begin
      strb[i] = !partial || (i < n_bytes);
    end
  end

endmodule

// File: rtl/redmule_z_store_gen.sv
// Z store generator: turns accepted Z rows into strobed TCDM store beats,
// walking rows/blocks with d0/d2 strides and pulsing done after the last store.
module redmule_z_store_gen
  import redmule_z_store_gen_pkg::*;
#(
  parameter int unsigned DATA_W      = Z_DATA_W,
  parameter int unsigned DATAW       = Z_DATAW,
  parameter int unsigned BITW        = Z_BITW,
  parameter int unsigned ADDR_W      = Z_ADDR_W,
  parameter int unsigned ARRAY_WIDTH = Z_ARRAY_WIDTH,
  parameter int unsigned STRB        = DATA_W / 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  input  logic                               start_i,
  input  logic [ADDR_W-1:0]                  z_addr_i,
  input  logic [31:0]                        z_d0_stride_i,
  input  logic [31:0]                        z_d2_stride_i,
  input  logic [15:0]                        n_blocks_i,
  input  logic [15:0]                        col_blocks_i,
  input  logic [$clog2(ARRAY_WIDTH):0]       rows_lftovr_i,
  input  logic [$clog2(DATAW/BITW):0]        cols_lftovr_i,
  input  logic                               z_valid_i,
  output logic                               z_ready_o,
  input  logic [DATAW-1:0]                   z_data_i,
  output logic                               st_valid_o,
  input  logic                               st_ready_i,
  output logic [ADDR_W-1:0]                  st_addr_o,
  output logic [DATA_W-1:0]                  st_data_o,
  output logic [STRB-1:0]                    st_strb_o,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int unsigned MEM_DW = DATA_W - DATAW;

  z_store_ctrl_t  ctrl;
  z_store_flgs_t  flgs;
  z_store_state_e state_q, state_d;

  logic [31:0]         d0_q, d2_q;
  logic [15:0]         nblk_q, colb_q;
  logic [Z_RLFT_W-1:0] rlft_q;
  logic [Z_CLFT_W-1:0] clft_q;

  logic [ADDR_W-1:0]   blk_base_q, cur_addr_q, st_addr_q;
  logic [Z_RLFT_W-1:0] r_q;
  logic [15:0]         b_q, c_q;
  logic                all_rows_q;
  logic                st_valid_q;
  logic [DATAW-1:0]    st_payload_q;
  logic [STRB-1:0]     st_strb_q;

  logic [Z_RLFT_W-1:0] rows_in_blk;
  logic [STRB-1:0]     row_strb;
  logic                last_blk, last_col, last_row;
  logic                z_ready, accept, out_fire, final_fire;

  assign ctrl = '{
    start:       start_i,
    clear:       clear_i,
    addr:        z_addr_i,
    d0_stride:   z_d0_stride_i,
    d2_stride:   z_d2_stride_i,
    n_blocks:    n_blocks_i,
    col_blocks:  col_blocks_i,
    rows_lftovr: rows_lftovr_i,
    cols_lftovr: cols_lftovr_i
  };

  assign last_blk    = (b_q == nblk_q - 16'd1);
  assign last_col    = (c_q == colb_q - 16'd1);
  assign rows_in_blk = rows_in_block(last_blk, rlft_q);
  assign last_row    = (r_q == rows_in_blk - Z_RLFT_W'(1));

  // Input side stalls once every row of the job has been taken.
  assign z_ready    = (state_q == Z_RUN) && !all_rows_q && (!st_valid_q || st_ready_i);
  assign accept     = z_valid_i && z_ready;
  assign out_fire   = st_valid_q && st_ready_i;
  assign final_fire = (state_q == Z_RUN) && all_rows_q && out_fire;

  redmule_z_strb_gen #(
    .DATA_W (DATA_W),
    .DATAW  (DATAW),
    .BITW   (BITW),
    .LFT_W  (Z_CLFT_W),
    .STRB   (STRB)
  ) i_strb_gen (
    .partial (last_col && (clft_q != '0)),
    .lftovr  (clft_q),
    .strb    (row_strb)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= Z_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      Z_IDLE:  if (ctrl.start) state_d = Z_RUN;
      Z_RUN:   if (final_fire) state_d = Z_DONE;
      Z_DONE:  state_d = Z_IDLE;
      default: state_d = Z_IDLE;
    endcase
    if (ctrl.clear) state_d = Z_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d0_q         <= '0;
      d2_q         <= '0;
      nblk_q       <= '0;
      colb_q       <= '0;
      rlft_q       <= '0;
      clft_q       <= '0;
      blk_base_q   <= '0;
      cur_addr_q   <= '0;
      r_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      all_rows_q   <= 1'b0;
      st_valid_q   <= 1'b0;
      st_addr_q    <= '0;
      st_payload_q <= '0;
      st_strb_q    <= '0;
    end else if (ctrl.clear) begin
      d0_q         <= '0;
      d2_q         <= '0;
      nblk_q       <= '0;
      colb_q       <= '0;
      rlft_q       <= '0;
      clft_q       <= '0;
      blk_base_q   <= '0;
      cur_addr_q   <= '0;
      r_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      all_rows_q   <= 1'b0;
      st_valid_q   <= 1'b0;
      st_addr_q    <= '0;
      st_payload_q <= '0;
      st_strb_q    <= '0;
    end else begin
      if ((state_q == Z_IDLE) && ctrl.start) begin
        d0_q       <= ctrl.d0_stride;
        d2_q       <= ctrl.d2_stride;
        nblk_q     <= ctrl.n_blocks;
        colb_q     <= ctrl.col_blocks;
        rlft_q     <= ctrl.rows_lftovr;
        clft_q     <= ctrl.cols_lftovr;
        blk_base_q <= ctrl.addr;
        cur_addr_q <= ctrl.addr;
        r_q        <= '0;
        b_q        <= '0;
        c_q        <= '0;
        all_rows_q <= 1'b0;
      end
      if (accept) begin
        st_valid_q   <= 1'b1;
        st_addr_q    <= cur_addr_q;
        st_payload_q <= z_data_i;
        st_strb_q    <= row_strb;
        if (!last_row) begin
          r_q        <= r_q + Z_RLFT_W'(1);
          cur_addr_q <= cur_addr_q + ADDR_W'(d0_q);
        end else begin
          r_q        <= '0;
          b_q        <= b_q + 16'd1;
          c_q        <= last_col ? '0 : c_q + 16'd1;
          blk_base_q <= blk_base_q + ADDR_W'(d2_q);
          cur_addr_q <= blk_base_q + ADDR_W'(d2_q);
          if (last_blk) all_rows_q <= 1'b1;
        end
      end else if (st_ready_i) begin
        st_valid_q <= 1'b0;
      end
    end
  end

  assign flgs = '{
    busy:     (state_q == Z_RUN),
    done:     (state_q == Z_DONE),
    st_valid: st_valid_q,
    st_strb:  st_strb_q
  };

  assign z_ready_o  = z_ready;
  assign st_valid_o = flgs.st_valid;
  assign st_addr_o  = st_addr_q;
  assign st_data_o  = {{MEM_DW{1'b0}}, st_payload_q};
  assign st_strb_o  = flgs.st_strb;
  assign busy_o     = flgs.busy;
  assign done_o     = flgs.done;

endmodule

// File: tb/tb_redmule_z_store_gen.sv
// Self-checking bench for redmule_z_store_gen: table of jobs, reference
// address/strobe list per job, scoreboard queue compared on each store beat.
module tb_redmule_z_store_gen;

  logic         clk = 1'b0;
  logic         rst_i, clear_i, start_i;
  logic [31:0]  z_addr_i, z_d0_stride_i, z_d2_stride_i;
  logic [15:0]  n_blocks_i, col_blocks_i;
  logic [4:0]   rows_lftovr_i, cols_lftovr_i;
  logic         z_valid_i, z_ready_o;
  logic [255:0] z_data_i;
  logic         st_valid_o, st_ready_i;
  logic [31:0]  st_addr_o;
  logic [287:0] st_data_o;
  logic [35:0]  st_strb_o;
  logic         busy_o, done_o;

  always #5 clk = ~clk;

  redmule_z_store_gen dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .z_addr_i      (z_addr_i),
    .z_d0_stride_i (z_d0_stride_i),
    .z_d2_stride_i (z_d2_stride_i),
    .n_blocks_i    (n_blocks_i),
    .col_blocks_i  (col_blocks_i),
    .rows_lftovr_i (rows_lftovr_i),
    .cols_lftovr_i (cols_lftovr_i),
    .z_valid_i     (z_valid_i),
    .z_ready_o     (z_ready_o),
    .z_data_i      (z_data_i),
    .st_valid_o    (st_valid_o),
    .st_ready_i    (st_ready_i),
    .st_addr_o     (st_addr_o),
    .st_data_o     (st_data_o),
    .st_strb_o     (st_strb_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  typedef struct {
    logic [31:0] base;
    logic [31:0] d0;
    logic [31:0] d2;
    int          nb;
    int          cb;
    int          rl;
    int          cl;
    int          stall_at;
    bit          gaps;
    bit          restart;
    int          exp_beats;
  } vec_t;

  typedef struct {
    logic [31:0]  addr;
    logic [35:0]  strb;
    logic [255:0] data;
  } beat_t;

  vec_t  vecs [7];
  beat_t rows [$];
  beat_t sb [$];

  int checks = 0;
  int failures = 0;
  int idx, nrows, beats_out, stall_cnt, stall_at, cycle, first_fire, last_fire;
  bit gaps, stall_used, done_due, done_checked, job_over, hold_prev;
  logic [31:0]  prev_addr;
  logic [287:0] prev_data;
  logic [35:0]  prev_strb;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference beat list built straight from the addressing rules.
  task automatic build_rows(input vec_t v);
    beat_t       bt;
    logic [31:0] base;
    logic [35:0] s;
    int          nr;
    rows.delete();
    for (int blk = 0; blk < v.nb; blk++) begin
      nr   = (blk == v.nb - 1 && v.rl != 0) ? v.rl : 12;
      base = v.base + 32'(blk) * v.d2;
      if ((blk % v.cb) == v.cb - 1 && v.cl != 0) s = (36'd1 << (v.cl * 2)) - 36'd1;
      else                                       s = 36'h0_FFFF_FFFF;
      for (int row = 0; row < nr; row++) begin
        bt.addr = base + 32'(row) * v.d0;
        bt.strb = s;
        for (int k = 0; k < 8; k++) bt.data[k*32 +: 32] = $urandom();
        rows.push_back(bt);
      end
    end
  endtask

  task automatic cycle_step();
    beat_t exp_b;
    bit    acc, fire;
    if (stall_at >= 0 && beats_out == stall_at && !stall_used) begin
      stall_cnt  = 4;
      stall_used = 1;
    end
    st_ready_i = (stall_cnt == 0);
    if (stall_cnt > 0) stall_cnt--;
    z_valid_i = (idx >= nrows) ? !gaps : (!gaps || $urandom_range(0, 3) != 0);
    z_data_i  = (idx < nrows) ? rows[idx].data : '0;
    @(negedge clk);
    if (hold_prev) begin
      chk("hold_valid", 288'(st_valid_o), 288'(1));
      chk("hold_addr", 288'(st_addr_o), 288'(prev_addr));
      chk("hold_data", st_data_o, prev_data);
      chk("hold_strb", 288'(st_strb_o), 288'(prev_strb));
    end
    chk("done", 288'(done_o), 288'(done_due));
    chk("busy", 288'(busy_o), 288'(!job_over));
    if (done_due) done_checked = 1;
    if (st_valid_o && !st_ready_i) chk("stall_zready", 288'(z_ready_o), 288'(0));
    acc  = z_valid_i && z_ready_o;
    fire = st_valid_o && st_ready_i;
    if (acc) begin
      if (idx >= nrows) chk("no_extra_accept", 288'(acc), 288'(0));
      else begin
        sb.push_back(rows[idx]);
        idx++;
      end
    end
    done_due = 0;
    if (fire) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got addr %0h expected no beat", st_addr_o);
      end else begin
        exp_b = sb.pop_front();
        chk("st_addr", 288'(st_addr_o), 288'(exp_b.addr));
        chk("st_strb", 288'(st_strb_o), 288'(exp_b.strb));
        chk("st_data", st_data_o, {32'h0, exp_b.data});
      end
      beats_out++;
      if (first_fire < 0) first_fire = cycle;
      last_fire = cycle;
      if (beats_out == nrows) begin
        done_due = 1;
        job_over = 1;
      end
    end
    hold_prev = st_valid_o && !st_ready_i;
    prev_addr = st_addr_o;
    prev_data = st_data_o;
    prev_strb = st_strb_o;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic setup_job(input vec_t v);
    build_rows(v);
    sb.delete();
    nrows = rows.size();
    idx = 0; beats_out = 0; stall_cnt = 0; stall_used = 0;
    stall_at = v.stall_at; gaps = v.gaps;
    done_due = 0; done_checked = 0; job_over = 0; hold_prev = 0;
    first_fire = -1; last_fire = -1;
    z_addr_i = v.base; z_d0_stride_i = v.d0; z_d2_stride_i = v.d2;
    n_blocks_i = 16'(v.nb); col_blocks_i = 16'(v.cb);
    rows_lftovr_i = 5'(v.rl); cols_lftovr_i = 5'(v.cl);
    z_valid_i = 0; st_ready_i = 1; start_i = 1;
    @(posedge clk);
    #1;
    start_i = 0;
  endtask

  task automatic run_job(input vec_t v);
    int n;
    setup_job(v);
    n = 0;
    while (!done_checked && n < 2000) begin
      if (v.restart && n == 3) begin
        start_i = 1; z_addr_i = 32'hDEAD_0000; n_blocks_i = 16'd1;
      end else start_i = 0;
      cycle_step();
      n++;
    end
    start_i = 0;
    if (!done_checked) chk("job_timeout", 288'(n), 288'(0));
    chk("beat_count", 288'(beats_out), 288'(v.exp_beats));
    chk("sb_empty", 288'(sb.size()), 288'(0));
    if (v.stall_at < 0 && !v.gaps) chk("no_bubble", 288'(last_fire - first_fire), 288'(v.exp_beats - 1));
    z_valid_i = 0;
    @(negedge clk);
    chk("idle_done", 288'(done_o), 288'(0));
    chk("idle_busy", 288'(busy_o), 288'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h0000_1000, 32'h40, 32'h400,   1, 1, 0,  0, -1, 0, 0, 12};
    vecs[1] = '{32'h0000_1000, 32'h40, 32'h400,   2, 2, 0,  5, -1, 0, 0, 24};
    vecs[2] = '{32'h0000_1000, 32'h40, 32'h400,   2, 1, 3,  0, -1, 0, 0, 15};
    vecs[3] = '{32'h0000_2000, 32'h40, 32'h400,   2, 1, 0,  0,  5, 0, 0, 24};
    vecs[4] = '{32'hFFFF_FFC0, 32'h40, 32'h400,   1, 1, 0,  0, -1, 0, 0, 12};
    vecs[5] = '{32'h0000_0000, 32'h20, 32'h1000,  5, 2, 7,  3,  9, 1, 1, 55};
    vecs[6] = '{32'h0000_0500, 32'h40, 32'h400,   1, 1, 1, 16, -1, 0, 0,  1};

    rst_i = 1; clear_i = 0; start_i = 0; z_valid_i = 0; st_ready_i = 1;
    z_addr_i = '0; z_d0_stride_i = '0; z_d2_stride_i = '0; n_blocks_i = 16'd1;
    col_blocks_i = 16'd1; rows_lftovr_i = '0; cols_lftovr_i = '0; z_data_i = '0;
    cycle = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 0;
    @(negedge clk);
    chk("rst_st_valid", 288'(st_valid_o), 288'(0));
    chk("rst_busy", 288'(busy_o), 288'(0));
    chk("rst_done", 288'(done_o), 288'(0));
    chk("rst_z_ready", 288'(z_ready_o), 288'(0));
    chk("rst_st_addr", 288'(st_addr_o), 288'(0));
    chk("rst_st_strb", 288'(st_strb_o), 288'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // Clear mid-job: outputs drop, no done, then a fresh job replays from base.
    setup_job(vecs[0]);
    for (int n = 0; n < 100 && beats_out < 5; n++) cycle_step();
    chk("clear_reached_beat5", 288'(beats_out), 288'(5));
    clear_i = 1; z_valid_i = 1; st_ready_i = 1;
    @(posedge clk);
    #1;
    clear_i = 0; z_valid_i = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("clear_st_valid", 288'(st_valid_o), 288'(0));
      chk("clear_busy", 288'(busy_o), 288'(0));
      chk("clear_done", 288'(done_o), 288'(0));
      chk("clear_z_ready", 288'(z_ready_o), 288'(0));
      @(posedge clk);
      #1;
    end
    run_job(vecs[0]);

    // Asynchronous reset mid-job clears outputs without waiting for an edge.
    setup_job(vecs[0]);
    for (int n = 0; n < 4; n++) cycle_step();
    rst_i = 1;
    #2;
    chk("arst_st_valid", 288'(st_valid_o), 288'(0));
    chk("arst_busy", 288'(busy_o), 288'(0));
    chk("arst_st_addr", 288'(st_addr_o), 288'(0));
    chk("arst_z_ready", 288'(z_ready_o), 288'(0));
    @(posedge clk);
    #1;
    rst_i = 0;
    z_valid_i = 0;
    @(negedge clk);
    chk("arst_idle_busy", 288'(busy_o), 288'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/redmule_z_store_gen.md
Name: redmule_z_store_gen

Overview:
- Write-side counterpart of the X/W load path: accepts Z result rows from the Z buffer and issues strobed TCDM store beats.
- Generates the store address stream (base + row and block strides) and the byte strobes, including row and column leftovers.
- Drives the z_valid/z_strb flags consumed by the scheduler and pulses done after the final store.
- Sits between the Z buffer and the HCI sink streamer.

Parameters:
- DATA_W, 288, TCDM port width in bits
- DATAW, 256, payload width (DATA_W - MemDw)
- BITW, 16, element width in bits
- ADDR_W, 32, address width
- ARRAY_WIDTH, 12, rows per full block
- STRB, DATA_W/8, strobe width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- clear_i  in  1  synchronous soft clear
- start_i  in  1  latch config, begin job
- z_addr_i  in  ADDR_W  Z base byte address
- z_d0_stride_i  in  32  byte stride between rows
- z_d2_stride_i  in  32  byte stride between blocks
- n_blocks_i  in  16  total blocks in job (>=1)
- col_blocks_i  in  16  blocks per block-row (>=1)
- rows_lftovr_i  in  $clog2(ARRAY_WIDTH)+1  rows in final block; 0 = ARRAY_WIDTH
- cols_lftovr_i  in  $clog2(DATAW/BITW)+1  valid elements in last column block; 0 = full
- z_valid_i  in  1  Z row valid
- z_ready_o  out  1  Z row accepted
- z_data_i  in  DATAW  Z row payload
- st_valid_o  out  1  store beat valid
- st_ready_i  in  1  store beat accepted
- st_addr_o  out  ADDR_W  store address
- st_data_o  out  DATA_W  {MemDw'0, payload}
- st_strb_o  out  STRB  byte strobes
- busy_o  out  1  job active
- done_o  out  1  one-cycle pulse after last store accepted

Behaviour:
- Reset/clear: all outputs 0; FSM in IDLE; counters and address registers 0. clear_i has priority over all other inputs and drops st_valid_o even mid-beat.
- FSM states:
  - IDLE: start_i latches all config and sets blk_base = cur_addr = z_addr_i, r = 0, b = 0, c = 0; go to RUN.
  - RUN: busy_o = 1.
  - DONE: one cycle, done_o = 1, then IDLE.
- start_i outside IDLE is ignored.
- Handshake: single output register stage.
  - z_ready_o = RUN && (!st_valid_o || st_ready_i).
  - An input accept loads st_* on the next edge; latency is 1 cycle; no bubbles under continuous valid/ready.
  - st_* stay stable while st_valid_o && !st_ready_i.
- Per accepted row:
  - st_addr_o = cur_addr.
  - st_strb_o[DATAW/8-1:0] is all ones, except when c == col_blocks-1 and cols_lftovr != 0: then only the low cols_lftovr*BITW/8 bits are set.
  - st_strb_o upper MemDw/8 bits are always 0.
- Row limit: rows_in_block = (b == n_blocks-1 && rows_lftovr != 0) ? rows_lftovr : ARRAY_WIDTH.
- Counter update on accept:
  - If r < rows_in_block-1: r++, cur_addr += d0.
  - Otherwise: r = 0, b++, c = (c == col_blocks-1) ? 0 : c+1, blk_base += d2, cur_addr = blk_base + d2.
- All address arithmetic wraps modulo 2^ADDR_W.
- Job end: after the last row of block n_blocks-1 is accepted, z_ready_o is forced to 0. The FSM goes to DONE on the cycle the final beat is accepted downstream, and done_o asserts on the following cycle.
- Simultaneous final output handshake and clear_i: clear wins and no done_o is generated.
- Asynchronous reset mid-job abandons the job and returns all outputs to 0 immediately.

Decomposition:
- Shared package gets:
  - z_store_ctrl_t: config fields plus start/clear.
  - z_store_flgs_t: busy, done, st_valid, st_strb.
  - the state enum z_store_state_e.
- One sub-module, redmule_z_strb_gen: a combinational leftover-to-byte-strobe decoder, reusable by the Y load path.

Test Plan:
- Base 0x1000, d0 0x40, d2 0x400, n_blocks 1, rows_lftovr 0, cols_lftovr 0, ready=1 -> 12 beats at 0x1000..0x12C0 step 0x40, all low strobes set, done_o pulses 1 cycle after the 12th beat.
- n_blocks 2, col_blocks 2, cols_lftovr 5 -> block 0 strobes 0x0FFFFFFFF; block 1 strobes 0x0000003FF; block 1 starts at 0x1400.
- n_blocks 2, rows_lftovr 3 -> 12 beats, then 3 beats from base+d2, 15 stores total, then done_o.
- st_ready_i low for 4 cycles mid-job -> st_* held stable, z_ready_o = 0, no beat lost or duplicated; sequence matches the reference address list.
- clear_i asserted at beat 5 -> st_valid_o and busy_o drop the next cycle, no done_o; a fresh start_i replays from the base address.
- Base 0xFFFFFFC0, d0 0x40 -> second beat address 0x00000000 (wrap).
